// File: rtl/pcileech_tx_256_32.sv
// pcileech_tx_256_32: 256-bit to 32-bit TX downsizer between pcileech_fifo
// and the deep FT601 output FIFO, with ring buffer, overflow flag and level.
//
// Ports:
//   clk, rst_n         FT601 clock, asynchronous active-low reset
//   din, din_valid     256-bit word strobe (no ready; accepted or dropped)
//   dout, dout_valid   32-bit dword stream, dword 0 (din[31:0]) first
//   dout_almost_full   deep FIFO almost_full, stalls the serializer
//   level              256-bit words buffered (serializer word excluded)
//   busy               buffer non-empty or serializer holding a word
//   overflow           sticky, set when a word is dropped while full
`timescale 1ns/1ps
module pcileech_tx_256_32 #(
   parameter int DEPTH      = 4,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [255:0]          din,
   input  logic                  din_valid,
   output logic [31:0]           dout,
   output logic                  dout_valid,
   input  logic                  dout_almost_full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  busy,
   output logic                  overflow
);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2:0]   r_wp;
   logic [DEPTH_LOG2:0]   r_rp;
   logic [255:0]          r_mem [DEPTH];
   logic [255:0]          r_sr;
   logic [255:0]          w_sr_nxt;
   logic [2:0]            r_idx;
   logic [2:0]            w_idx_nxt;
   logic [7:0]            w_bit;
   logic [31:0]           r_dout;
   logic [31:0]           w_dout_nxt;
   logic                  r_dout_vld;
   logic                  w_dout_vld_nxt;
   logic                  r_ovf;
   logic [DEPTH_LOG2:0]   w_level;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [255:0]          w_head;

   assign w_level = r_wp - r_rp;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == (DEPTH_LOG2+1)'(DEPTH));
   assign w_head  = r_mem[r_rp[DEPTH_LOG2-1:0]];
   assign w_bit   = {r_idx, 5'b00000};

   // A pop in the same edge frees a slot, so a full buffer still accepts.
   assign w_push  = din_valid & (~w_full | w_pop);
   assign w_drop  = din_valid & w_full & ~w_pop;

   always_comb begin
      w_state_nxt    = r_state;
      w_sr_nxt       = r_sr;
      w_idx_nxt      = r_idx;
      w_dout_nxt     = r_dout;
      w_dout_vld_nxt = 1'b0;
      w_pop          = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sr_nxt    = w_head;
               w_idx_nxt   = 3'd0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!dout_almost_full) begin
               w_dout_nxt     = r_sr[w_bit +: 32];
               w_dout_vld_nxt = 1'b1;
               w_idx_nxt      = r_idx + 3'd1;
               // Reload on the last dword so words stream without a bubble.
               if (r_idx == 3'd7) begin
                  if (!w_empty) begin
                     w_pop    = 1'b1;
                     w_sr_nxt = w_head;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_sr       <= '0;
         r_idx      <= '0;
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sr       <= w_sr_nxt;
         r_idx      <= w_idx_nxt;
         r_dout     <= w_dout_nxt;
         r_dout_vld <= w_dout_vld_nxt;
         if (w_push) begin
            r_wp <= r_wp + (DEPTH_LOG2+1)'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + (DEPTH_LOG2+1)'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp[DEPTH_LOG2-1:0]] <= din;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_vld;
   assign level      = w_level;
   assign busy       = (w_level != '0) | (r_state == S_SHIFT);
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_pcileech_tx_256_32.sv
// tb_pcileech_tx_256_32: directed stimulus with a dword scoreboard for the
// 256-to-32 TX downsizer; a negedge monitor pops and compares every dword.
`timescale 1ns/1ps
module tb_pcileech_tx_256_32;

   localparam int DEPTH = 4;
   localparam int DL2   = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [255:0]   din = '0;
   logic           din_valid = 1'b0;
   logic [31:0]    dout;
   logic           dout_valid;
   logic           af = 1'b0;
   logic [DL2:0]   level;
   logic           busy;
   logic           overflow;

   int             n_pass = 0;
   int             n_chk = 0;
   logic [31:0]    q[$];
   int             cyc = 0;
   int             mon_cnt = 0;
   int             mon_first = -1;
   int             mon_last = -1;
   int             lvl_max = 0;

   always #5 clk = ~clk;

   pcileech_tx_256_32 #(
      .DEPTH(DEPTH),
      .DEPTH_LOG2(DL2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .din_valid(din_valid),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_almost_full(af),
      .level(level),
      .busy(busy),
      .overflow(overflow)
   );

   function automatic logic [255:0] mkw(input int w);
      logic [255:0] r;
      logic [7:0]   wb;
      r = '0;
      wb = w[7:0];
      for (int k = 0; k < 8; k++) begin
         if (w == 0) r[32*k +: 32] = 32'(32'h11111111 * k);
         else r[32*k +: 32] = {wb, 8'hC3, 8'h5A, 8'(k)};
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h required %08h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (dout_valid === 1'b1) begin
         mon_cnt++;
         if (mon_first < 0) mon_first = cyc;
         mon_last = cyc;
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_dout: got %08h required none", dout);
         end else begin
            chk("dout_order", dout, q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mon_cnt = 0;
      mon_first = -1;
      mon_last = -1;
   endtask

   task automatic push_word(input int w, input bit exp_in);
      logic [255:0] v;
      v = mkw(w);
      din = v;
      din_valid = 1'b1;
      if (exp_in) begin
         for (int k = 0; k < 8; k++) q.push_back(v[32*k +: 32]);
      end
      step();
      din_valid = 1'b0;
      din = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din_valid = 1'b0;
      af = 1'b0;
      q.delete();
      #1;
      chk("rst_dout", dout, 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_until_idle(input int maxc, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (!busy && !dout_valid) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s_idle: got busy after %0d cycles required idle",
                    nm, maxc);
   endtask

   task automatic wait_valids(input int n, input int maxc, input string nm);
      int seen;
      seen = 0;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (dout_valid) seen++;
         if (seen == n) break;
      end
      n_chk++;
      if (seen == n) n_pass++;
      else $display("FAIL %s_wait: got %0d valids required %0d", nm, seen, n);
   endtask

   task automatic single_word(input int w, input string nm);
      logic [255:0] v;
      v = mkw(w);
      clr_mon();
      push_word(w, 1'b1);
      chk({nm, "_level1"}, 32'(level), 32'd1);
      step();
      chk({nm, "_lat_e1"}, 32'(dout_valid), 32'd0);
      step();
      chk({nm, "_lat_e2"}, 32'(dout_valid), 32'd1);
      chk({nm, "_dw0"}, dout, v[31:0]);
      run_until_idle(30, nm);
      chk({nm, "_count"}, 32'(mon_cnt), 32'd8);
      chk({nm, "_span"}, 32'(mon_last - mon_first + 1), 32'd8);
      chk({nm, "_level0"}, 32'(level), 32'd0);
      chk({nm, "_busy0"}, 32'(busy), 32'd0);
      chk({nm, "_drained"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      logic [255:0] v;
      #2;
      do_reset();

      single_word(0, "t1");

      clr_mon();
      lvl_max = 0;
      for (int w = 1; w <= 4; w++) push_word(w, 1'b1);
      run_until_idle(60, "t2");
      chk("t2_count", 32'(mon_cnt), 32'd32);
      chk("t2_span", 32'(mon_last - mon_first + 1), 32'd32);
      chk("t2_peak", 32'(lvl_max), 32'd3);
      chk("t2_drained", 32'(q.size()), 32'd0);

      clr_mon();
      v = mkw(5);
      push_word(5, 1'b1);
      wait_valids(3, 20, "t3");
      af = 1'b1;
      low = 0;
      repeat (5) begin
         step();
         if (!dout_valid) low++;
      end
      af = 1'b0;
      step();
      chk("t3_resume_valid", 32'(dout_valid), 32'd1);
      chk("t3_resume_dw3", dout, v[127:96]);
      chk("t3_stall_cycles", 32'(low), 32'd5);
      run_until_idle(30, "t3");
      chk("t3_count", 32'(mon_cnt), 32'd8);
      chk("t3_drained", 32'(q.size()), 32'd0);

      af = 1'b1;
      for (int w = 10; w <= 15; w++) push_word(w, w < 15);
      chk("t4_level_full", 32'(level), 32'd4);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_stalled", 32'(dout_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      clr_mon();
      af = 1'b0;
      run_until_idle(100, "t4");
      chk("t4_count", 32'(mon_cnt), 32'd40);
      chk("t4_sticky", 32'(overflow), 32'd1);
      chk("t4_drained", 32'(q.size()), 32'd0);

      do_reset();
      af = 1'b1;
      for (int w = 20; w <= 24; w++) push_word(w, 1'b1);
      chk("t5_level_full", 32'(level), 32'd4);
      af = 1'b0;
      wait_valids(7, 20, "t5");
      chk("t5_still_full", 32'(level), 32'd4);
      push_word(25, 1'b1);
      chk("t5_level_kept", 32'(level), 32'd4);
      chk("t5_no_overflow", 32'(overflow), 32'd0);
      run_until_idle(100, "t5");
      chk("t5_drained", 32'(q.size()), 32'd0);
      chk("t5_no_overflow_end", 32'(overflow), 32'd0);

      do_reset();
      push_word(6, 1'b1);
      wait_valids(4, 20, "t6");
      do_reset();
      single_word(0, "t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pcileech_tx_256_32.md
Name: pcileech_tx_256_32

Overview:
- Downsizing TX stage between pcileech_fifo (256-bit ft601_tx_data/ft601_tx_valid, no backpressure) and the 32-bit deep output FIFO feeding pcileech_ft601.
- Replaces the 256→32 FIFO primitive with a small RTL buffer plus a serializer that honours the deep FIFO's almost_full.
- Adds an overflow indication and a fill level.

Parameters:
DEPTH, 4, number of 256-bit entries in the ring buffer; must be a power of two, at least 2.
DEPTH_LOG2, 2, log2(DEPTH); sets pointer width.

Ports:
clk  input  1  FT601_CLK domain; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
din  input  256  word from pcileech_fifo; dword k = din[32k+31:32k].
din_valid  input  1  single-cycle write strobe; there is no ready signal, and the word is accepted or dropped.
dout  output  32  dword to the deep FIFO din.
dout_valid  output  1  write enable to the deep FIFO.
dout_almost_full  input  1  deep FIFO almost_full; used as backpressure.
level  output  DEPTH_LOG2+1  number of 256-bit words buffered, excluding the word in the serializer.
busy  output  1  high when level != 0 or the serializer holds a word.
overflow  output  1  sticky flag; set when a word is dropped.

Behaviour:
- Interface: one clock (clk); asynchronous, active-low reset (rst_n).
- Reset values (asynchronous, while rst_n = 0):
  - dout = 0, dout_valid = 0, level = 0, busy = 0, overflow = 0.
  - Pointers = 0, serializer state = IDLE, index = 0.
  - Buffer RAM contents are don't-care.
- Reset asserted mid-operation discards all buffered and partially serialized data. No dout_valid is issued after rst_n falls.
- Ring buffer:
  - Write pointer wp and read pointer rp are DEPTH_LOG2+1 bits wide.
  - level = wp - rp, modulo 2^(DEPTH_LOG2+1).
  - full when level == DEPTH; empty when level == 0.
- Push: din_valid=1 at an edge and (not full, or a pop occurs at the same edge) → din is written at wp[DEPTH_LOG2-1:0] and wp increments.
- Drop: din_valid=1 while full with no pop at the same edge → word discarded, wp unchanged, overflow <= 1. overflow stays set until reset.
- Serializer FSM (registered outputs):
  - IDLE:
    - If not empty: pop the buffer[rp] word into shift register sr, rp++, index <= 0, go to SHIFT.
    - dout_valid <= 0.
  - SHIFT, dout_almost_full = 0 at the edge:
    - dout <= sr[32*index+31 : 32*index], dout_valid <= 1, index++.
    - If index == 7: when not empty, pop the next word into sr in the same edge and stay in SHIFT (index wraps to 0); otherwise go to IDLE.
  - SHIFT, dout_almost_full = 1 at the edge:
    - dout_valid <= 0; index, sr and dout hold.
- Emission order is dword 0 first (din[31:0]) through dword 7 (din[255:224]).
- Latency: push at edge E0 into an empty buffer with the serializer in IDLE → pop at E1 → first dout_valid=1 after E2.
- Throughput: with almost_full low, back-to-back words stream one dword per cycle with no bubbles between 256-bit words.
- Simultaneous push and pop at the same edge: level unchanged. This is legal even when full.
- Word integrity: a 256-bit word is never partially dropped. Backpressure only stalls the serializer; it never discards data.
- busy = (level != 0) | (state == SHIFT), registered.

Test Plan:
1. Single word: din = {8 dwords 0x77777777..0x00000000} with din_valid pulsed once → dout_valid high on 8 consecutive cycles starting 2 clocks after the capture edge; dout sequence 0x00000000, 0x11111111, …, 0x77777777; then busy = 0 and level = 0.
2. Streaming: 4 words pushed on consecutive cycles with almost_full = 0 → exactly 32 contiguous dout_valid cycles in order; level peaks at 3; no gap at word boundaries.
3. Backpressure: assert almost_full for 5 cycles after the 3rd dword → dout_valid low for exactly those 5 cycles; dword 3 is emitted next; no duplicates or losses.
4. Overflow: hold almost_full = 1 and push 6 words (DEPTH = 4) → level = 4, the serializer holds word 0, the 6th word is dropped and overflow = 1. On almost_full release, exactly 40 dwords (words 0–4) are output.
5. Full with simultaneous pop: buffer full and serializer emitting dword 7 when din_valid = 1 → word accepted, overflow stays 0, level stays 4.
6. Reset mid-stream: drop rst_n during the 4th dword → dout_valid = 0 and level = 0 immediately. After release, a new single word is emitted cleanly per test 1.
